// File: rtl/oam_dma_ctrl.sv
// Sprite DMA controller: stalls the CPU, copies one page of memory into the OAM data port.
// Optional macro OAM_DMA_ODD_ALIGN_EN makes the ALIGN cycle depend on a free-running parity bit.
module oam_dma_ctrl #(
    parameter int unsigned            ADDR_WIDTH    = 16,
    parameter int unsigned            REG_WIDTH     = 8,
    parameter logic [ADDR_WIDTH-1:0]  DMA_TRIG_ADDR = 16'h4014,
    parameter logic [ADDR_WIDTH-1:0]  OAM_DATA_ADDR = 16'h2004,
    parameter int unsigned            XFER_LEN      = 256
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [REG_WIDTH-1:0]  cpu_wdata,
    input  logic                  cpu_r_w_n,
    output logic                  cpu_rdy,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [REG_WIDTH-1:0]  mem_din,
    input  logic [REG_WIDTH-1:0]  mem_dout,
    output logic                  dma_busy,
    output logic                  dma_done
);

    localparam logic [7:0] IdxLast = 8'(XFER_LEN - 1);

    typedef enum logic [2:0] {StIdle, StHalt, StAlign, StRd, StWr} state_e;

    state_e               state_q, state_d;
    logic [REG_WIDTH-1:0] page_q, page_d;
    logic [REG_WIDTH-1:0] data_q, data_d;
    logic [7:0]           idx_q, idx_d;
    logic                 done_q, done_d;
    logic                 trig;
    logic                 halt_to_align;

    assign trig = ~cpu_r_w_n && (cpu_addr == DMA_TRIG_ADDR);

`ifdef OAM_DMA_ODD_ALIGN_EN
    logic parity_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ~parity_q;
        end
    end

    assign halt_to_align = parity_q;
`else
    assign halt_to_align = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            page_q  <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        data_d  = data_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (trig) begin
                    page_d  = cpu_wdata;
                    idx_d   = '0;
                    state_d = StHalt;
                end
            end
            // The CPU only honours rdy on reads, so wait out any pending writes.
            StHalt: begin
                if (cpu_r_w_n) begin
                    state_d = halt_to_align ? StAlign : StRd;
                end
            end
            StAlign: state_d = StRd;
            StRd: begin
                data_d  = mem_dout;
                state_d = StWr;
            end
            StWr: begin
                if (idx_q == IdxLast) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = StRd;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cpu_rdy  = 1'b1;
        dma_busy = 1'b0;
        mem_addr = cpu_addr;
        mem_we   = ~cpu_r_w_n;
        mem_din  = cpu_wdata;
        unique case (state_q)
            StIdle: ;
            StHalt: begin
                cpu_rdy  = 1'b0;
                dma_busy = 1'b1;
            end
            StAlign: begin
                cpu_rdy  = 1'b0;
                dma_busy = 1'b1;
                mem_we   = 1'b0;
            end
            StRd: begin
                cpu_rdy  = 1'b0;
                dma_busy = 1'b1;
                mem_addr = ADDR_WIDTH'({page_q, idx_q});
                mem_we   = 1'b0;
            end
            StWr: begin
                cpu_rdy  = 1'b0;
                dma_busy = 1'b1;
                mem_addr = OAM_DATA_ADDR;
                mem_we   = 1'b1;
                mem_din  = data_q;
            end
            default: ;
        endcase
    end

    assign dma_done = done_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Scoreboard bench for oam_dma_ctrl: expected OAM bytes and pass-through writes are queued
// by the stimulus and popped by a negedge monitor.
module tb_oam_dma_ctrl;

    localparam logic [15:0] TrigAddr = 16'h4014;
    localparam logic [15:0] OamAddr  = 16'h2004;
    localparam logic [15:0] IdleAddr = 16'h8000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] cpu_addr = IdleAddr;
    logic [7:0]  cpu_wdata = 8'h00;
    logic        cpu_r_w_n = 1'b1;
    logic        cpu_rdy;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic        dma_busy;
    logic        dma_done;

    oam_dma_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_r_w_n (cpu_r_w_n),
        .cpu_rdy   (cpu_rdy),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout),
        .dma_busy  (dma_busy),
        .dma_done  (dma_done)
    );

    always #5 clk = ~clk;

    // Memory contents as a pure function of address; page FF differs from the rest.
    function automatic logic [7:0] pat(input logic [15:0] a);
        if (a[15:8] == 8'hFF) return a[7:0] ^ 8'hC3;
        return a[7:0] ^ 8'h5A;
    endfunction

    assign mem_dout = pat(mem_addr);

    logic [7:0]  oam_q[$];
    logic [23:0] pt_q[$];
    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int oam_cnt = 0;
    logic [7:0]  exp_b;
    logic [23:0] exp_w;

    always @(negedge clk) begin
        if (reset_n) begin
            if (dma_done) done_cnt++;
            if (dma_busy) begin
                total++;
                if (mem_addr == 16'h0000) begin
                    bad++;
                    $display("FAIL zero_addr: mem_addr=%h while busy, required nonzero", mem_addr);
                end
            end
            if (mem_we && mem_addr == OamAddr) begin
                oam_cnt++;
                total++;
                if (oam_q.size() == 0) begin
                    bad++;
                    $display("FAIL oam_extra: got write data %h, required no write", mem_din);
                end else begin
                    exp_b = oam_q.pop_front();
                    if (mem_din !== exp_b) begin
                        bad++;
                        $display("FAIL oam_data: got %h, required %h", mem_din, exp_b);
                    end
                end
            end else if (mem_we) begin
                total++;
                if (pt_q.size() == 0) begin
                    bad++;
                    $display("FAIL pt_extra: got %h<=%h, required no write", mem_addr, mem_din);
                end else begin
                    exp_w = pt_q.pop_front();
                    if ({mem_addr, mem_din} !== exp_w) begin
                        bad++;
                        $display("FAIL pt_write: got %h<=%h, required %h<=%h",
                                 mem_addr, mem_din, exp_w[23:8], exp_w[7:0]);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic cpu_cycle(input logic [15:0] a, input logic rw, input logic [7:0] d);
        cpu_addr  = a;
        cpu_r_w_n = rw;
        cpu_wdata = d;
        if (!rw) pt_q.push_back({a, d});
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_idle();
        cpu_addr  = IdleAddr;
        cpu_r_w_n = 1'b1;
        cpu_wdata = 8'h00;
    endtask

    task automatic queue_page(input logic [7:0] page);
        for (int i = 0; i < 256; i++) begin
            oam_q.push_back(pat({page, i[7:0]}));
        end
    endtask

    // Trigger, optional writes during HALT, then count stalled cycles after the writes.
    task automatic run_dma(input string name, input logic [7:0] page, input int n_extra,
                           input logic [15:0] xa0, input logic [7:0] xd0,
                           input logic [15:0] xa1, input logic [7:0] xd1);
        int cnt;
        bit ended;
        queue_page(page);
        cpu_cycle(TrigAddr, 1'b0, page);
        if (n_extra > 0) cpu_cycle(xa0, 1'b0, xd0);
        if (n_extra > 1) cpu_cycle(xa1, 1'b0, xd1);
        cpu_idle();
        cnt = 0;
        ended = 1'b0;
        for (int k = 0; k < 2000 && !ended; k++) begin
            @(negedge clk);
            if (cpu_rdy !== 1'b0) ended = 1'b1;
            else cnt++;
        end
        check({name, "_ended"}, 32'(ended), 32'd1);
`ifdef OAM_DMA_ODD_ALIGN_EN
        check({name, "_rdy_low"}, 32'(cnt == 513 || cnt == 514), 32'd1);
`else
        check({name, "_rdy_low"}, 32'(cnt), 32'd514);
`endif
        check({name, "_done_hi"}, 32'(dma_done), 32'd1);
        check({name, "_busy_lo"}, 32'(dma_busy), 32'd0);
        check({name, "_left"}, 32'(oam_q.size()), 32'd0);
        @(negedge clk);
        check({name, "_done_lo"}, 32'(dma_done), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int saved_done;
        bit hit;

        #2;
        check("rst_rdy", 32'(cpu_rdy), 32'd1);
        check("rst_busy", 32'(dma_busy), 32'd0);
        check("rst_done", 32'(dma_done), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'(IdleAddr));
        cpu_addr  = 16'h1234;
        cpu_r_w_n = 1'b0;
        cpu_wdata = 8'h9C;
        #1;
        check("rst_pt_we", 32'(mem_we), 32'd1);
        check("rst_pt", 32'({mem_addr, mem_din}), 32'({16'h1234, 8'h9C}));
        cpu_idle();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        run_dma("t1", 8'h02, 0, 16'h0, 8'h0, 16'h0, 8'h0);
        run_dma("t2a", 8'h02, 0, 16'h0, 8'h0, 16'h0, 8'h0);
        @(posedge clk);
        #1;
        run_dma("t2b", 8'h02, 0, 16'h0, 8'h0, 16'h0, 8'h0);
        run_dma("t3", 8'h05, 2, 16'h0300, 8'hAA, 16'h0301, 8'h55);
        run_dma("t4", 8'hFF, 0, 16'h0, 8'h0, 16'h0, 8'h0);
        run_dma("t6", 8'h02, 1, TrigAddr, 8'h07, 16'h0, 8'h0);
        check("pt_left", 32'(pt_q.size()), 32'd0);

        // Reset in the middle of a transfer.
        saved_done = done_cnt;
        base = oam_cnt;
        queue_page(8'h03);
        cpu_cycle(TrigAddr, 1'b0, 8'h03);
        cpu_idle();
        hit = 1'b0;
        for (int k = 0; k < 1000 && !hit; k++) begin
            @(negedge clk);
            if (oam_cnt >= base + 100) hit = 1'b1;
        end
        check("t5_reached", 32'(hit), 32'd1);
        #1;
        check("t5_busy_before", 32'(dma_busy), 32'd1);
        cpu_addr  = 16'h0500;
        cpu_wdata = 8'h33;
        cpu_r_w_n = 1'b0;
        reset_n   = 1'b0;
        #1;
        check("t5_rdy", 32'(cpu_rdy), 32'd1);
        check("t5_busy", 32'(dma_busy), 32'd0);
        check("t5_we", 32'(mem_we), 32'd1);
        check("t5_pt", 32'({mem_addr, mem_din}), 32'({16'h0500, 8'h33}));
        check("t5_done", 32'(dma_done), 32'd0);
        oam_q.delete();
        @(posedge clk);
        #1;
        cpu_idle();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) @(negedge clk);
        check("t5_no_done", 32'(done_cnt), 32'(saved_done));
        check("t5_idle", 32'(dma_busy), 32'd0);
        check("done_total", 32'(done_cnt), 32'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
